// File: rtl/proc_pkg.sv
// Shared processor constants: datapath widths and multiplier depth.
// Used by the MUL pipeline and the decode-stage hazard/bypass unit.
package proc_pkg;

  localparam int ARCH_BITS    = 32;
  localparam int REG_IDX_BITS = 5;
  localparam int MUL_STAGES   = 5;
  localparam int MUL_ACC_LAST = 3;

  typedef struct packed {
    logic                    valid;
    logic                    we;
    logic [REG_IDX_BITS-1:0] dst;
  } mul_tag_t;

endpackage

// File: rtl/mul_stage.sv
// One multiplier pipeline register: adds the partial product of
// operand A and chunk K of operand B into the running accumulator.
import proc_pkg::*;

module mul_stage #(
  parameter int ARCH_BITS    = proc_pkg::ARCH_BITS,
  parameter int REG_IDX_BITS = proc_pkg::REG_IDX_BITS,
  parameter int CHUNK        = ARCH_BITS / 4,
  parameter int K            = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_hold,
  input  logic                    i_flush,
  input  logic                    i_valid,
  input  logic                    i_we,
  input  logic [REG_IDX_BITS-1:0] i_dst,
  input  logic [ARCH_BITS-1:0]    i_a,
  input  logic [ARCH_BITS-1:0]    i_b,
  input  logic [ARCH_BITS-1:0]    i_acc,
  output logic                    o_valid,
  output logic                    o_we,
  output logic [REG_IDX_BITS-1:0] o_dst,
  output logic [ARCH_BITS-1:0]    o_a,
  output logic [ARCH_BITS-1:0]    o_b,
  output logic [ARCH_BITS-1:0]    o_acc
);

  localparam int SHIFT = K * CHUNK;

  logic                    r_valid;
  logic                    r_we;
  logic [REG_IDX_BITS-1:0] r_dst;
  logic [ARCH_BITS-1:0]    r_a;
  logic [ARCH_BITS-1:0]    r_b;
  logic [ARCH_BITS-1:0]    r_acc;

  logic [ARCH_BITS-1:0]    w_bz;
  logic [ARCH_BITS-1:0]    w_pp;
  logic [ARCH_BITS-1:0]    w_sum;

  assign w_bz  = ARCH_BITS'(i_b[SHIFT +: CHUNK]);
  assign w_pp  = i_a * w_bz;
  assign w_sum = i_acc + (w_pp << SHIFT);

  // Bubbles carry zeroed tags so the bypass unit never matches them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_dst   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_dst   <= '0;
      r_acc   <= '0;
    end else if (!i_hold) begin
      r_valid <= i_valid;
      r_we    <= i_valid & i_we;
      r_dst   <= i_valid ? i_dst : '0;
      r_a     <= i_a;
      r_b     <= i_b;
      r_acc   <= i_valid ? w_sum : '0;
    end
  end

  assign o_valid = r_valid;
  assign o_we    = r_we;
  assign o_dst   = r_dst;
  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_acc   = r_acc;

endmodule

// File: rtl/mul_pipeline.sv
// Five-stage 32x32 low-half multiplier with per-stage producer
// info for the bypass unit and a stage-4 writeback register.
import proc_pkg::*;

module mul_pipeline #(
  parameter int ARCH_BITS    = proc_pkg::ARCH_BITS,
  parameter int REG_IDX_BITS = proc_pkg::REG_IDX_BITS,
  parameter int CHUNK        = ARCH_BITS / 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [ARCH_BITS-1:0]                in_a,
  input  logic [ARCH_BITS-1:0]                in_b,
  input  logic [REG_IDX_BITS-1:0]             in_dst,
  input  logic                                in_we,
  output logic                                in_ready,
  input  logic                                stall,
  input  logic                                flush,
  output logic [MUL_STAGES-1:0]               byp_valid,
  output logic [MUL_STAGES-1:0]               byp_we,
  output logic [MUL_STAGES*REG_IDX_BITS-1:0]  byp_dst,
  output logic [MUL_STAGES*ARCH_BITS-1:0]     byp_data,
  output logic                                wb_valid,
  output logic                                wb_we,
  output logic [REG_IDX_BITS-1:0]             wb_dst,
  output logic [ARCH_BITS-1:0]                wb_data
);

  localparam int NS = MUL_STAGES;

  logic                    w_iv   [NS-1];
  logic                    w_iw   [NS-1];
  logic [REG_IDX_BITS-1:0] w_id   [NS-1];
  logic [ARCH_BITS-1:0]    w_ia   [NS-1];
  logic [ARCH_BITS-1:0]    w_ib   [NS-1];
  logic [ARCH_BITS-1:0]    w_iacc [NS-1];

  logic                    w_v    [NS];
  logic                    w_w    [NS];
  logic [REG_IDX_BITS-1:0] w_d    [NS];
  logic [ARCH_BITS-1:0]    w_acc  [NS];
  logic [ARCH_BITS-1:0]    w_a    [NS-1];
  logic [ARCH_BITS-1:0]    w_b    [NS-1];

  logic                    r4_valid;
  logic                    r4_we;
  logic [REG_IDX_BITS-1:0] r4_dst;
  logic [ARCH_BITS-1:0]    r4_acc;

  assign in_ready = ~stall;

  assign w_iv[0]   = in_valid;
  assign w_iw[0]   = in_we;
  assign w_id[0]   = in_dst;
  assign w_ia[0]   = in_a;
  assign w_ib[0]   = in_b;
  assign w_iacc[0] = '0;

  for (genvar k = 1; k < NS - 1; k++) begin : g_link
    assign w_iv[k]   = w_v[k-1];
    assign w_iw[k]   = w_w[k-1];
    assign w_id[k]   = w_d[k-1];
    assign w_ia[k]   = w_a[k-1];
    assign w_ib[k]   = w_b[k-1];
    assign w_iacc[k] = w_acc[k-1];
  end

  for (genvar k = 0; k < NS - 1; k++) begin : g_stage
    mul_stage #(
      .ARCH_BITS    (ARCH_BITS),
      .REG_IDX_BITS (REG_IDX_BITS),
      .CHUNK        (CHUNK),
      .K            (k)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_hold  (stall),
      .i_flush (flush),
      .i_valid (w_iv[k]),
      .i_we    (w_iw[k]),
      .i_dst   (w_id[k]),
      .i_a     (w_ia[k]),
      .i_b     (w_ib[k]),
      .i_acc   (w_iacc[k]),
      .o_valid (w_v[k]),
      .o_we    (w_w[k]),
      .o_dst   (w_d[k]),
      .o_a     (w_a[k]),
      .o_b     (w_b[k]),
      .o_acc   (w_acc[k])
    );
  end

  // Stage 4 is committed: flush only stops stage 3 from refilling it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r4_valid <= 1'b0;
      r4_we    <= 1'b0;
      r4_dst   <= '0;
      r4_acc   <= '0;
    end else if (!stall) begin
      r4_valid <= w_v[NS-2] & ~flush;
      r4_we    <= w_w[NS-2] & ~flush;
      r4_dst   <= flush ? '0 : w_d[NS-2];
      r4_acc   <= flush ? '0 : w_acc[NS-2];
    end
  end

  assign w_v[NS-1]   = r4_valid;
  assign w_w[NS-1]   = r4_we;
  assign w_d[NS-1]   = r4_dst;
  assign w_acc[NS-1] = r4_acc;

  for (genvar k = 0; k < NS; k++) begin : g_byp
    assign byp_valid[k] = w_v[k];
    assign byp_dst[k*REG_IDX_BITS +: REG_IDX_BITS] = w_d[k];
    assign byp_data[k*ARCH_BITS +: ARCH_BITS]      = w_acc[k];
    if (k >= MUL_ACC_LAST) begin : g_final
      assign byp_we[k] = w_v[k] & w_w[k];
    end else begin : g_partial
      assign byp_we[k] = 1'b0;
    end
  end

  assign wb_valid = r4_valid;
  assign wb_we    = r4_we;
  assign wb_dst   = r4_dst;
  assign wb_data  = r4_acc;

endmodule

// File: tb/tb_mul_pipeline.sv
// Directed bench for mul_pipeline: reset, latency, wrap, stall,
// flush and non-writing ops against hand-computed products.
module tb_mul_pipeline;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [31:0]  in_a;
  logic [31:0]  in_b;
  logic [4:0]   in_dst;
  logic         in_we;
  logic         in_ready;
  logic         stall;
  logic         flush;
  logic [4:0]   byp_valid;
  logic [4:0]   byp_we;
  logic [24:0]  byp_dst;
  logic [159:0] byp_data;
  logic         wb_valid;
  logic         wb_we;
  logic [4:0]   wb_dst;
  logic [31:0]  wb_data;

  int n_chk = 0;
  int n_err = 0;

  mul_pipeline dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_dst    (in_dst),
    .in_we     (in_we),
    .in_ready  (in_ready),
    .stall     (stall),
    .flush     (flush),
    .byp_valid (byp_valid),
    .byp_we    (byp_we),
    .byp_dst   (byp_dst),
    .byp_data  (byp_data),
    .wb_valid  (wb_valid),
    .wb_we     (wb_we),
    .wb_dst    (wb_dst),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input logic we);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_dst   = d;
    in_we    = we;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_dst   = '0;
    in_we    = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    issue(a, b, 5'd1, 1'b1);
    tick();
    idle();
    repeat (4) tick();
    chk({tag, "_valid"}, 64'(wb_valid), 64'd1);
    chk({tag, "_data"}, 64'(wb_data), 64'(exp));
  endtask

  logic [31:0] got_d [3];
  logic [4:0]  got_r [3];
  int          n_wb;
  logic [4:0]  exp_v;

  initial begin
    rst   = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    issue(32'd5, 32'd5, 5'd3, 1'b1);
    repeat (2) tick();
    chk("rst_byp_valid", 64'(byp_valid), 64'd0);
    chk("rst_byp_we", 64'(byp_we), 64'd0);
    chk("rst_byp_dst", 64'(byp_dst), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    chk("rst_wb_dst", 64'(wb_dst), 64'd0);
    idle();
    rst = 1'b1;
    tick();
    chk("in_ready", 64'(in_ready), 64'd1);

    // basic latency and bypass-enable timing
    issue(32'h0000_1234, 32'h0000_5678, 5'd7, 1'b1);
    tick();
    idle();
    for (int i = 1; i <= 5; i++) begin
      exp_v = (i == 4) ? 5'b01000 : (i == 5) ? 5'b10000 : 5'b00000;
      chk($sformatf("basic_byp_we_c%0d", i), 64'(byp_we), 64'(exp_v));
      chk($sformatf("basic_byp_valid_c%0d", i), 64'(byp_valid),
          64'(5'b00001 << (i - 1)));
      if (i < 5) tick();
    end
    chk("basic_wb_valid", 64'(wb_valid), 64'd1);
    chk("basic_wb_we", 64'(wb_we), 64'd1);
    chk("basic_wb_dst", 64'(wb_dst), 64'd7);
    chk("basic_wb_data", 64'(wb_data), 64'h0626_0060);
    chk("basic_byp_dst4", 64'(byp_dst[24:20]), 64'd7);
    chk("basic_byp_data3", 64'(byp_data[127:96]), 64'd0);
    tick();
    chk("basic_drain", 64'(wb_valid), 64'd0);

    run_one("wrap_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_one("wrap_80", 32'h8000_0000, 32'h0000_0002, 32'h0000_0000);
    run_one("mid", 32'h0001_0001, 32'h0101_0101, 32'h0202_0101);
    tick();

    // back-to-back with a two-cycle stall
    issue(32'd2, 32'd3, 5'd1, 1'b1);
    tick();
    issue(32'd4, 32'd5, 5'd2, 1'b1);
    tick();
    issue(32'd6, 32'd7, 5'd3, 1'b1);
    tick();
    issue(32'd9, 32'd9, 5'd4, 1'b1);
    stall = 1'b1;
    #1;
    chk("stall_ready0", 64'(in_ready), 64'd0);
    tick();
    chk("stall_hold1", 64'(byp_valid), 64'b00111);
    chk("stall_ready1", 64'(in_ready), 64'd0);
    tick();
    chk("stall_hold2", 64'(byp_valid), 64'b00111);
    stall = 1'b0;
    idle();
    n_wb = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wb_valid) begin
        if (n_wb < 3) begin
          got_d[n_wb] = wb_data;
          got_r[n_wb] = wb_dst;
        end
        n_wb++;
      end
    end
    chk("stall_count", 64'(n_wb), 64'd3);
    chk("stall_d0", 64'(got_d[0]), 64'd6);
    chk("stall_d1", 64'(got_d[1]), 64'd20);
    chk("stall_d2", 64'(got_d[2]), 64'd42);
    chk("stall_r0", 64'(got_r[0]), 64'd1);
    chk("stall_r2", 64'(got_r[2]), 64'd3);

    // flush with ops in stages 0, 2 and 4
    issue(32'd3, 32'd3, 5'd10, 1'b1);
    tick();
    idle();
    tick();
    issue(32'd4, 32'd4, 5'd11, 1'b1);
    tick();
    idle();
    tick();
    issue(32'd5, 32'd5, 5'd12, 1'b1);
    tick();
    chk("fl_pre_valid", 64'(byp_valid), 64'b10101);
    chk("fl_pre_wb", 64'(wb_valid), 64'd1);
    chk("fl_pre_dst", 64'(wb_dst), 64'd10);
    chk("fl_pre_data", 64'(wb_data), 64'd9);
    issue(32'd6, 32'd6, 5'd13, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    chk("fl_post_valid", 64'(byp_valid), 64'd0);
    chk("fl_post_dst", 64'(byp_dst), 64'd0);
    n_wb = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wb_valid) n_wb++;
    end
    chk("fl_no_write", 64'(n_wb), 64'd0);

    // flush under stall keeps stage 4
    issue(32'd7, 32'd3, 5'd14, 1'b1);
    tick();
    idle();
    repeat (2) tick();
    issue(32'd8, 32'd8, 5'd15, 1'b1);
    tick();
    idle();
    tick();
    chk("fs_pre_valid", 64'(byp_valid), 64'b10010);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    stall = 1'b0;
    flush = 1'b0;
    chk("fs_valid", 64'(byp_valid), 64'b10000);
    chk("fs_wb_data", 64'(wb_data), 64'd21);
    tick();
    chk("fs_drain", 64'(byp_valid), 64'd0);

    // non-writing op is visible but never bypassable
    issue(32'd2, 32'd2, 5'd9, 1'b0);
    tick();
    idle();
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("we0_valid_c%0d", i), 64'(byp_valid),
          64'(5'b00001 << (i - 1)));
      chk($sformatf("we0_dst_c%0d", i),
          64'(byp_dst[(i-1)*5 +: 5]), 64'd9);
      chk($sformatf("we0_byp_we_c%0d", i), 64'(byp_we), 64'd0);
      if (i < 5) tick();
    end
    chk("we0_wb_valid", 64'(wb_valid), 64'd1);
    chk("we0_wb_we", 64'(wb_we), 64'd0);
    chk("we0_wb_data", 64'(wb_data), 64'd4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
